bcd_alarm_clock: RTL
====================

Name: bcd_alarm_clock

Overview:
- Parametrised BCD timekeeper (HH:MM:SS:hundredths) with a programmable alarm and a timed alarm output.
- Successor to the fixed-format clock front-end. It adds a real-time prescaler, cascaded BCD rollover, 12/24-hour mode, load validation and an alarm sounding timer.
- Outputs packed BCD for the downstream 7-segment decoder; it does no display decode itself.

Parameters:
- CLK_HZ, 50000000, input clock frequency. Must be an integer multiple of TICK_HZ, with ratio >= 2.
- TICK_HZ, 100, rate of the least-significant field (hundredths).
- MODE_12H, 0, 0 = hours 00..23; 1 = hours 01..12 with a pm flag.
- ALARM_SECS, 30, seconds alarm_sound stays asserted if not cleared, 1..255.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- time_in  in  8  BCD value to load, {tens, units}.
- field_sel  in  2  target field: 3 = hours, 2 = minutes, 1 = seconds, 0 = hundredths.
- load_time  in  1  level; a rising edge loads time_in into the time field.
- load_alarm  in  1  level; a rising edge loads time_in into the alarm field.
- alarm_en  in  1  arms alarm matching.
- alarm_clear  in  1  level; while high, forces alarm_sound low.
- time_bcd  out  32  {HH, MM, SS, hh} BCD, registered.
- alarm_bcd  out  32  same packing, registered.
- pm  out  1  PM indicator (MODE_12H = 1), else 0.
- tick  out  1  one-cycle pulse per hundredth advance.
- alarm_sound  out  1  alarm active.
- load_err  out  1  one-cycle pulse: a load was rejected.

Behaviour:
- Reset (async assert, sync release):
  - time_bcd = 0x00000000 and alarm_bcd = 0x00000000 in 24h mode. In 12h mode both hour fields are 0x12.
  - pm = 0, tick = 0, alarm_sound = 0, load_err = 0.
  - Prescaler = 0, edge-detect registers = 0.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ.
  - tick asserts in the cycle the count equals DIV-1.
  - The count wraps to 0. It is never reset by loads.
- Advance on tick (registered, same clock edge):
  - hh 00..99 → on wrap, SS 00..59 → on wrap, MM 00..59 → on wrap, hours.
  - 24h mode: hours 23 → 00.
  - 12h mode: hours 11 → 12 toggles pm; hours 12 → 01 leaves pm unchanged.
  - Each field carries only on its own wrap, with BCD units/tens handling (e.g. 0x09 → 0x10, 0x59 → 0x00).
- Load:
  - A rising edge is detected against a one-cycle delayed copy of load_time or load_alarm. The action occurs in the cycle after the input goes high.
- Load validation: reject the load (target unchanged, load_err pulses 1 cycle) when any of the following holds:
  - either nibble > 9;
  - the value exceeds the field maximum: 99 for hh, 59 for SS/MM, 23 for 24h hours;
  - in 12h mode, hours is 00 or > 12.
- Loading hours in 12h mode does not change pm.
- Accepted time load:
  - Writes the selected field.
  - A tick in the same cycle is dropped; no field advances that cycle.
  - The hundredths counter is not cleared unless field_sel = 0.
- Simultaneous load_time and load_alarm edges:
  - The time load is performed, the alarm load is discarded, and load_err pulses.
- Alarm match:
  - Condition: alarm_en = 1, the post-advance time has HH:MM:SS equal to alarm_bcd[31:8], and the advance just carried into hh = 00.
  - Evaluated only on tick cycles, so it fires once per matching second.
  - hh of the alarm is ignored.
  - In 12h mode, pm is not compared; the alarm fires twice per day.
  - A match sets alarm_sound the next cycle and loads the sound counter with ALARM_SECS.
- Sounding:
  - The counter decrements on each seconds carry. alarm_sound clears when the counter reaches 0.
  - alarm_clear = 1 forces alarm_sound = 0 and the counter = 0, and blocks a new match while high.
  - alarm_en falling also clears the alarm.
- Retrigger: a match while already sounding reloads the counter.
- A time load that makes the time equal to the alarm does not trigger; only an advance does.
- Reset mid-sound returns all outputs to their reset values immediately.

Test Plan:
- CLK_HZ=1000, TICK_HZ=100, release reset → tick every 10 cycles; after 100 ticks time_bcd = 0x00000100.
- Load hours = 0x23, minutes = 0x59, seconds = 0x59, hh = 0x99, then 1 tick → time_bcd = 0x00000000.
  - Same with MODE_12H=1, hours = 0x11, pm = 0 → time_bcd = 0x12000000, pm = 1.
  - From 0x12595999, 1 tick → 0x01000000, pm unchanged.
- Load time_in = 0x5A, 0x60 to minutes and 0x24 to hours (24h) → each gives a load_err pulse, time_bcd unchanged.
  - 12h mode, load 0x00 to hours → load_err.
- alarm_bcd = 0x00000200, alarm_en = 1, ALARM_SECS = 3, run from 0 → alarm_sound rises 1 cycle after time reaches 0x00000200, falls when time reaches 0x00000500.
  - Repeat with alarm_clear pulsed at 0x00000300 → alarm_sound falls the next cycle and stays low.
- Load_time rising edge coincident with tick → loaded field takes time_in, other fields do not advance that cycle.
  - Simultaneous load_time/load_alarm → only time updates, load_err = 1.
- Assert rst_n low mid-sound and mid-prescale → all outputs at reset values in the same cycle; the first tick comes DIV cycles after release.

Source files
------------

// File: rtl/bcd_alarm_clock_if.sv
// Bundle of load controls and BCD outputs for bcd_alarm_clock.
// Handshake rules: there is no valid/ready pair. load_time and load_alarm are
// levels, and only a 0->1 transition requests a load. field_sel and time_in are
// sampled in the same cycle as that transition. load_err is a one-cycle
// registered pulse that reports a rejected request. All outputs are registered,
// except tick, which decodes the registered prescaler.
interface bcd_alarm_clock_if;
  logic [7:0]  time_in;
  logic [1:0]  field_sel;
  logic        load_time;
  logic        load_alarm;
  logic        alarm_en;
  logic        alarm_clear;
  logic [31:0] time_bcd;
  logic [31:0] alarm_bcd;
  logic        pm;
  logic        tick;
  logic        alarm_sound;
  logic        load_err;

  modport master (
    output time_in, field_sel, load_time, load_alarm, alarm_en, alarm_clear,
    input  time_bcd, alarm_bcd, pm, tick, alarm_sound, load_err
  );

  modport slave (
    input  time_in, field_sel, load_time, load_alarm, alarm_en, alarm_clear,
    output time_bcd, alarm_bcd, pm, tick, alarm_sound, load_err
  );
endinterface

// File: rtl/bcd_alarm_clock.sv
// BCD timekeeper HH:MM:SS:hh with a prescaler, 12/24-hour mode, validated
// field loads and an alarm that sounds for a fixed number of seconds.
module bcd_alarm_clock #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 100,
  parameter int MODE_12H   = 0,
  parameter int ALARM_SECS = 30
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  bcd_alarm_clock_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam bit            IS12       = (MODE_12H != 0);
  localparam logic [31:0]   RST_TIME   = IS12 ? 32'h1200_0000 : 32'h0000_0000;
  localparam logic [7:0]    SOUND_LOAD = 8'(ALARM_SECS);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   time_q, time_d, alarm_q, alarm_d, adv_time;
  logic          pm_q, pm_d, pm_adv;
  logic          lt_q, la_q, err_q, err_d, match_q, match_d, sound_q, sound_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick, t_rise, a_rise, t_ok, t_acc, a_acc, advance, sec_carry;
  logic          hh_wrap, ss_wrap, mm_wrap;

  // Increments a packed BCD byte by one. The caller handles the field wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Checks that a load value is legal for the selected field.
  function automatic logic load_ok(input logic [7:0] v, input logic [1:0] sel);
    logic ok;
    ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    case (sel)
      2'd1, 2'd2: ok = ok && (v <= 8'h59);
      2'd3:       ok = IS12 ? (ok && (v != 8'h00) && (v <= 8'h12))
                            : (ok && (v <= 8'h23));
      default:    ;
    endcase
    return ok;
  endfunction

  // Computes the time one hundredth later, with the cascaded carries.
  always_comb begin
    hh_wrap  = (time_q[7:0]   == 8'h99);
    ss_wrap  = (time_q[15:8]  == 8'h59);
    mm_wrap  = (time_q[23:16] == 8'h59);
    adv_time = time_q;
    pm_adv   = pm_q;
    adv_time[7:0] = hh_wrap ? 8'h00 : bcd_inc(time_q[7:0]);
    if (hh_wrap) begin
      adv_time[15:8] = ss_wrap ? 8'h00 : bcd_inc(time_q[15:8]);
      if (ss_wrap) begin
        adv_time[23:16] = mm_wrap ? 8'h00 : bcd_inc(time_q[23:16]);
        if (mm_wrap) begin
          if (IS12) begin
            if (time_q[31:24] == 8'h12) begin
              adv_time[31:24] = 8'h01;
            end else begin
              adv_time[31:24] = bcd_inc(time_q[31:24]);
              if (time_q[31:24] == 8'h11) pm_adv = ~pm_q;
            end
          end else begin
            adv_time[31:24] = (time_q[31:24] == 8'h23) ? 8'h00 : bcd_inc(time_q[31:24]);
          end
        end
      end
    end
  end

  // Decodes loads and the tick, and works out the next state of every register.
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    t_rise    = bus.load_time & ~lt_q;
    a_rise    = bus.load_alarm & ~la_q;
    t_ok      = load_ok(bus.time_in, bus.field_sel);
    t_acc     = t_rise & t_ok;
    // A time load wins over an alarm load in the same cycle, and the alarm load is reported as rejected.
    a_acc     = a_rise & ~t_rise & t_ok;
    err_d     = (t_rise & ~t_ok) | (a_rise & (t_rise | ~t_ok));
    // An accepted time load swallows a coincident tick.
    advance   = tick & ~t_acc;
    sec_carry = advance & hh_wrap;

    time_d = time_q;
    if (t_acc) time_d[{bus.field_sel, 3'b000} +: 8] = bus.time_in;
    else if (advance) time_d = adv_time;
    pm_d = advance ? pm_adv : pm_q;

    alarm_d = alarm_q;
    if (a_acc) alarm_d[{bus.field_sel, 3'b000} +: 8] = bus.time_in;

    // Only an advance into hh = 00 can match, so each matching second fires once.
    match_d = sec_carry & bus.alarm_en & ~bus.alarm_clear &
              (adv_time[31:8] == alarm_q[31:8]);

    sound_d = sound_q;
    cnt_d   = cnt_q;
    if (!bus.alarm_en || bus.alarm_clear) begin
      sound_d = 1'b0;
      cnt_d   = 8'd0;
    end else if (match_q) begin
      sound_d = 1'b1;
      cnt_d   = SOUND_LOAD;
    end else if (sound_q && sec_carry) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q <= 8'd1) sound_d = 1'b0;
    end
  end

  // Prescaler and load edge detectors.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      lt_q    <= 1'b0;
      la_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      lt_q    <= bus.load_time;
      la_q    <= bus.load_alarm;
    end
  end

  // Time, alarm and load error registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      time_q  <= RST_TIME;
      alarm_q <= RST_TIME;
      pm_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      alarm_q <= alarm_d;
      pm_q    <= pm_d;
      err_q   <= err_d;
    end
  end

  // Alarm match pulse and sounding timer.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      sound_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      match_q <= match_d;
      sound_q <= sound_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.time_bcd    = time_q;
  assign bus.alarm_bcd   = alarm_q;
  assign bus.pm          = pm_q;
  assign bus.tick        = tick;
  assign bus.alarm_sound = sound_q;
  assign bus.load_err    = err_q;
endmodule
